// File: rtl/mu0_boot_ctrl_if.sv
// Host image-load channel for mu0_boot_ctrl: the host drives words, the controller accepts them.
interface mu0_boot_ctrl_if #(
    parameter int unsigned DATA_W = 16
);
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic              load_last;

    modport master (
        output load_valid, load_data, load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid, load_data, load_last,
        output load_ready
    );
endinterface

// File: rtl/mu0_boot_ctrl.sv
// Boot/run sequencer for MU0: loads an image into memory, runs the CPU, reports done/timeout.
// Optional load checksum enabled by defining MU0_BOOT_CHECKSUM_EN.
module mu0_boot_ctrl #(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned MAX_WORDS      = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    mu0_boot_ctrl_if.slave     load,
    input  logic               rerun,
    input  logic               reload,
    output logic               cpu_rst,
    input  logic               cpu_running,
    input  logic [ADDR_W-1:0]  cpu_address,
    input  logic               cpu_write,
    input  logic               cpu_read,
    input  logic [DATA_W-1:0]  cpu_writedata,
    output logic [ADDR_W-1:0]  mem_address,
    output logic               mem_write,
    output logic               mem_read,
    output logic [DATA_W-1:0]  mem_writedata,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [31:0]        cycle_count,
    output logic [DATA_W-1:0]  load_checksum
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);
    localparam logic [31:0]       TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]       TO_FULL   = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_BOOT    = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] load_addr;
    logic              ready_q;
    logic              accept;
    logic              restart;

    assign load.load_ready = ready_q;
    assign accept  = (state == S_LOAD) && load.load_valid && ready_q;
    // A reload out of DONE/TIMEOUT restarts the image pointer and checksum.
    assign restart = ((state == S_DONE) || (state == S_TIMEOUT)) && reload;

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:    if (accept && (load.load_last || (load_addr == LAST_ADDR))) state_nxt = S_BOOT;
            S_BOOT:    state_nxt = S_RUN;
            S_RUN: begin
                if (!cpu_running)               state_nxt = S_DONE;
                else if (cycle_count == TO_LAST) state_nxt = S_TIMEOUT;
            end
            S_DONE, S_TIMEOUT: begin
                if (reload)     state_nxt = S_LOAD;
                else if (rerun) state_nxt = S_BOOT;
            end
            default:   state_nxt = S_LOAD;
        endcase
    end

    // State, counters and registered status outputs, decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_LOAD;
            load_addr   <= '0;
            cycle_count <= '0;
            ready_q     <= 1'b1;
            cpu_rst     <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == S_LOAD);
            cpu_rst <= (state_nxt != S_RUN) && (state_nxt != S_DONE);
            busy    <= (state_nxt == S_LOAD) || (state_nxt == S_BOOT) || (state_nxt == S_RUN);
            done    <= (state_nxt == S_DONE);
            timeout <= (state_nxt == S_TIMEOUT);

            if (restart)     load_addr <= '0;
            else if (accept) load_addr <= load_addr + ADDR_W'(1);

            if (state_nxt == S_BOOT) begin
                cycle_count <= '0;
            end else if ((state == S_RUN) && cpu_running) begin
                cycle_count <= (cycle_count == TO_LAST) ? TO_FULL : cycle_count + 32'd1;
            end
        end
    end

    // Memory bus: load writes in LOAD, CPU pass-through in RUN, idle otherwise
    always_comb begin
        mem_address   = '0;
        mem_write     = 1'b0;
        mem_read      = 1'b0;
        mem_writedata = '0;
        if (accept) begin
            mem_address   = load_addr;
            mem_write     = 1'b1;
            mem_writedata = load.load_data;
        end else if (state == S_RUN) begin
            mem_address   = cpu_address;
            mem_write     = cpu_write;
            mem_read      = cpu_read;
            mem_writedata = cpu_writedata;
        end
    end

`ifdef MU0_BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    // Running modulo sum of accepted image words
    always_ff @(posedge clk) begin
        if (rst || restart) checksum_q <= '0;
        else if (accept)    checksum_q <= checksum_q + load.load_data;
    end

    assign load_checksum = checksum_q;
`else
    assign load_checksum = '0;
`endif

endmodule

// File: tb/tb_mu0_boot_ctrl.sv
// Directed, table-driven bench for mu0_boot_ctrl (MAX_WORDS=4, TIMEOUT_CYCLES=100).
module tb_mu0_boot_ctrl;

`ifdef MU0_BOOT_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rerun, reload, cpu_rst, cpu_running;
    logic [11:0] cpu_address, mem_address;
    logic        cpu_write, cpu_read, mem_write, mem_read;
    logic [15:0] cpu_writedata, mem_writedata, load_checksum;
    logic        busy, done, timeout;
    logic [31:0] cycle_count;

    mu0_boot_ctrl_if #(.DATA_W(16)) lif ();

    mu0_boot_ctrl #(
        .ADDR_W(12), .DATA_W(16), .MAX_WORDS(4), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .load(lif.slave),
        .rerun(rerun), .reload(reload),
        .cpu_rst(cpu_rst), .cpu_running(cpu_running),
        .cpu_address(cpu_address), .cpu_write(cpu_write), .cpu_read(cpu_read),
        .cpu_writedata(cpu_writedata),
        .mem_address(mem_address), .mem_write(mem_write), .mem_read(mem_read),
        .mem_writedata(mem_writedata),
        .busy(busy), .done(done), .timeout(timeout),
        .cycle_count(cycle_count), .load_checksum(load_checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst, v;
        logic [15:0] d;
        logic        l, run, rr, rl;
        logic [11:0] ca;
        logic        cw, cr;
        logic [15:0] cd;
        logic        e_rdy, e_mw, e_mr;
        logic [11:0] e_ma;
        logic [15:0] e_md;
        logic        e_busy, e_done, e_to, e_crst;
        logic [31:0] e_cnt;
        logic        chk_cnt;
        logic [15:0] e_ck;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] ck_m = '0;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t blank();
        vec_t t;
        t     = '0;
        t.run = 1'b1;
        return t;
    endfunction

    // One LOAD cycle; cnt < 0 means the held count is not checked
    function automatic void ld(logic v, logic [15:0] d, logic l, logic [11:0] a, int cnt);
        vec_t t;
        t = blank();
        t.v = v; t.d = d; t.l = l;
        t.e_rdy = 1'b1; t.e_busy = 1'b1; t.e_crst = 1'b1;
        if (v) begin t.e_mw = 1'b1; t.e_ma = a; t.e_md = d; end
        t.chk_cnt = (cnt >= 0);
        t.e_cnt   = (cnt >= 0) ? 32'(cnt) : 32'd0;
        t.e_ck    = CK_EN ? ck_m : 16'h0;
        vecs.push_back(t);
        if (v) ck_m = ck_m + d;
    endfunction

    function automatic void boot(logic v, logic [15:0] d);
        vec_t t;
        t = blank();
        t.v = v; t.d = d;
        t.e_busy = 1'b1; t.e_crst = 1'b1;
        t.e_ck = CK_EN ? ck_m : 16'h0;
        vecs.push_back(t);
    endfunction

    function automatic void run(int cnt, logic running, logic [11:0] ca, logic cw, logic cr,
                                logic [15:0] cd, logic lv, logic r);
        vec_t t;
        t = blank();
        t.rst = r; t.v = lv; t.d = 16'hDEAD; t.run = running;
        t.ca = ca; t.cw = cw; t.cr = cr; t.cd = cd;
        t.e_mw = cw; t.e_mr = cr; t.e_ma = ca; t.e_md = cd;
        t.e_busy = 1'b1;
        t.chk_cnt = 1'b1; t.e_cnt = 32'(cnt);
        t.e_ck = CK_EN ? ck_m : 16'h0;
        vecs.push_back(t);
        if (r) ck_m = '0;
    endfunction

    // DONE/TIMEOUT cycle with a busy CPU bus and an offered host word: bus must stay idle
    function automatic void fin(logic is_to, int cnt, logic rr, logic rl);
        vec_t t;
        t = blank();
        t.v = 1'b1; t.d = 16'h1111; t.run = 1'b0; t.rr = rr; t.rl = rl;
        t.ca = 12'h5A5; t.cw = 1'b1; t.cr = 1'b1; t.cd = 16'hFFFF;
        t.e_done = !is_to; t.e_to = is_to; t.e_crst = is_to;
        t.chk_cnt = 1'b1; t.e_cnt = 32'(cnt);
        t.e_ck = CK_EN ? ck_m : 16'h0;
        vecs.push_back(t);
        if (rl) ck_m = '0;
    endfunction

    initial begin
        rst = 1'b1; rerun = 1'b0; reload = 1'b0; cpu_running = 1'b0;
        cpu_address = '0; cpu_write = 1'b0; cpu_read = 1'b0; cpu_writedata = '0;
        lif.load_valid = 1'b0; lif.load_data = '0; lif.load_last = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_cpu_rst", -1, 32'(cpu_rst), 32'd1);
        chk("rst_ready",   -1, 32'(lif.load_ready), 32'd1);
        chk("rst_busy",    -1, 32'(busy), 32'd1);
        chk("rst_done",    -1, 32'(done), 32'd0);
        chk("rst_timeout", -1, 32'(timeout), 32'd0);
        chk("rst_mem",     -1, {16'(mem_address), 14'd0, mem_write, mem_read}, 32'd0);
        chk("rst_wdata",   -1, 32'(mem_writedata), 32'd0);
        chk("rst_count",   -1, cycle_count, 32'd0);
        chk("rst_ck",      -1, 32'(load_checksum), 32'd0);
        @(posedge clk);
        #1;

        // Three-word image, 7 running cycles, then rerun, then rerun+reload
        ld(1'b1, 16'h0002, 1'b0, 12'd0, 0);
        ld(1'b1, 16'h7000, 1'b0, 12'd1, 0);
        ld(1'b1, 16'h0005, 1'b1, 12'd2, 0);
        boot(1'b0, 16'h0);
        for (int i = 0; i < 7; i++) run(i, 1'b1, 12'(i + 8), i[0], !i[0], 16'(i * 3), 1'b0, 1'b0);
        run(7, 1'b0, 12'h0FF, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
        fin(1'b0, 7, 1'b0, 1'b0);
        fin(1'b0, 7, 1'b1, 1'b0);
        boot(1'b0, 16'h0);
        for (int i = 0; i < 7; i++) run(i, 1'b1, 12'(i), 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
        run(7, 1'b0, 12'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        fin(1'b0, 7, 1'b1, 1'b1);

        // JMP 0 forever: timeout after 100 running cycles
        ld(1'b0, 16'h0, 1'b0, 12'd0, -1);
        ld(1'b1, 16'h4000, 1'b1, 12'd0, -1);
        boot(1'b0, 16'h0);
        for (int i = 0; i < 100; i++) run(i, 1'b1, 12'd0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
        fin(1'b1, 100, 1'b0, 1'b0);
        fin(1'b1, 100, 1'b0, 1'b1);

        // Gaps between words keep addresses contiguous; CPU stops at once
        ld(1'b1, 16'h00AA, 1'b0, 12'd0, -1);
        ld(1'b0, 16'h0BAD, 1'b0, 12'd0, -1);
        ld(1'b1, 16'h00BB, 1'b0, 12'd1, -1);
        ld(1'b0, 16'h0BAD, 1'b1, 12'd0, -1);
        ld(1'b1, 16'h00CC, 1'b1, 12'd2, -1);
        boot(1'b0, 16'h0);
        run(0, 1'b0, 12'h123, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
        fin(1'b0, 0, 1'b0, 1'b1);

        // MAX_WORDS=4: six words offered without last, only four written
        for (int i = 0; i < 4; i++) ld(1'b1, 16'(16'h0100 + i), 1'b0, 12'(i), -1);
        boot(1'b1, 16'h0104);
        run(0, 1'b0, 12'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        fin(1'b0, 0, 1'b0, 1'b1);

        // Reset mid-RUN, then reload the image and check the checksum
        ld(1'b1, 16'h0002, 1'b0, 12'd0, -1);
        ld(1'b1, 16'h7000, 1'b0, 12'd1, -1);
        ld(1'b1, 16'h0005, 1'b1, 12'd2, -1);
        boot(1'b0, 16'h0);
        run(0, 1'b1, 12'h010, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
        run(1, 1'b1, 12'h011, 1'b0, 1'b1, 16'h0, 1'b0, 1'b1);
        ld(1'b0, 16'h0, 1'b0, 12'd0, 0);
        ld(1'b1, 16'h0002, 1'b0, 12'd0, 0);
        ld(1'b1, 16'h7000, 1'b0, 12'd1, 0);
        ld(1'b1, 16'h0005, 1'b1, 12'd2, 0);
        boot(1'b0, 16'h0);
        run(0, 1'b0, 12'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        fin(1'b0, 0, 1'b0, 1'b0);

        foreach (vecs[k]) begin
            rst            = vecs[k].rst;
            lif.load_valid = vecs[k].v;
            lif.load_data  = vecs[k].d;
            lif.load_last  = vecs[k].l;
            cpu_running    = vecs[k].run;
            rerun          = vecs[k].rr;
            reload         = vecs[k].rl;
            cpu_address    = vecs[k].ca;
            cpu_write      = vecs[k].cw;
            cpu_read       = vecs[k].cr;
            cpu_writedata  = vecs[k].cd;
            @(negedge clk);
            chk("ready",     k, 32'(lif.load_ready), 32'(vecs[k].e_rdy));
            chk("mem_write", k, 32'(mem_write),      32'(vecs[k].e_mw));
            chk("mem_read",  k, 32'(mem_read),       32'(vecs[k].e_mr));
            chk("mem_addr",  k, 32'(mem_address),    32'(vecs[k].e_ma));
            chk("mem_wdata", k, 32'(mem_writedata),  32'(vecs[k].e_md));
            chk("busy",      k, 32'(busy),           32'(vecs[k].e_busy));
            chk("done",      k, 32'(done),           32'(vecs[k].e_done));
            chk("timeout",   k, 32'(timeout),        32'(vecs[k].e_to));
            chk("cpu_rst",   k, 32'(cpu_rst),        32'(vecs[k].e_crst));
            chk("checksum",  k, 32'(load_checksum),  32'(vecs[k].e_ck));
            if (vecs[k].chk_cnt) chk("cycle_count", k, cycle_count, vecs[k].e_cnt);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
